// File: rtl/rs232_tx_arb_pkg.sv
// Shared types and constants for the rs232 TX arbiter slice.
package rs232_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Bits needed to index v items; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs232_rr_pick.sv
// Rotating-priority encoder: first requester found scanning from i_rr_ptr upward, modulo NREQ.
module rs232_rr_pick
    import rs232_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_rr_ptr,
    output logic            o_valid,
    output logic [IDW-1:0]  o_idx
);

    localparam int unsigned CW = IDW + 1;

    logic [CW-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // rr_ptr and k are both below NREQ, so one subtraction wraps the sum
            w_cand = {1'b0, i_rr_ptr} + CW'(k);
            if (w_cand >= CW'(NREQ)) w_cand = w_cand - CW'(NREQ);
            if (!o_valid && i_req[w_cand[IDW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arb.sv
// Round-robin arbiter sharing one rs232_ser byte serializer between NREQ sources,
// with an optional inter-frame gap and an ack timeout.
module rs232_tx_arb
    import rs232_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned TIMEOUT_CYC = 2**20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ack,
    output logic [BYTE_W-1:0]        ser_tx_data,
    output logic                     ser_tx_req,
    input  logic                     ser_tx_ack,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned IDW     = clog2(NREQ);
    localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYC) ? GAP_CYCLES : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    state_t             r_state, w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDW-1:0]     r_grant, w_grant_nxt;
    logic [BYTE_W-1:0]  r_data, w_data_nxt;
    logic               r_tx_req, w_tx_req_nxt;
    logic [NREQ-1:0]    r_ack, w_ack_nxt;
    logic               r_tout, w_tout_nxt;

    logic               w_pick_valid;
    logic [IDW-1:0]     w_pick_idx;
    logic [IDW-1:0]     w_ptr_inc;

    rs232_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx)
    );

    assign w_ptr_inc = (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_grant  <= '0;
            r_data   <= '0;
            r_tx_req <= 1'b0;
            r_ack    <= '0;
            r_tout   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_grant  <= w_grant_nxt;
            r_data   <= w_data_nxt;
            r_tx_req <= w_tx_req_nxt;
            r_ack    <= w_ack_nxt;
            r_tout   <= w_tout_nxt;
        end
    end

    // One counter serves both the GRANT timeout and the GAP length; the states never overlap.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr_ptr;
        w_cnt_nxt    = r_cnt;
        w_grant_nxt  = r_grant;
        w_data_nxt   = r_data;
        w_tx_req_nxt = r_tx_req;
        w_ack_nxt    = '0;
        w_tout_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt  = w_pick_idx;
                    w_data_nxt   = req_data[BYTE_W*int'(w_pick_idx) +: BYTE_W];
                    w_tx_req_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (ser_tx_ack) begin
                    w_tx_req_nxt       = 1'b0;
                    w_ack_nxt[r_grant] = 1'b1;
                    w_rr_nxt           = w_ptr_inc;
                    w_cnt_nxt          = '0;
                    w_state_nxt        = GAP;
                end else if ((TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TO_LAST))) begin
                    w_tx_req_nxt = 1'b0;
                    w_tout_nxt   = 1'b1;
                    w_rr_nxt     = w_ptr_inc;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = GAP;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign req_ack     = r_ack;
    assign ser_tx_data = r_data;
    assign ser_tx_req  = r_tx_req;
    assign grant_id    = r_grant;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_tout;

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Directed bench for rs232_tx_arb: one instance with no gap and a 16-cycle timeout,
// one with a 5-cycle gap and an 8-cycle timeout, driven through a shared stimulus mux.
module tb_rs232_tx_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic [3:0]  d_req;
    logic [31:0] d_data;
    logic        d_ack;

    logic [3:0]  a_req, a_req_ack, b_req, b_req_ack;
    logic [7:0]  a_txd, b_txd;
    logic        a_txr, a_ack, a_busy, a_tout;
    logic        b_txr, b_ack, b_busy, b_tout;
    logic [1:0]  a_gid, b_gid;

    assign a_req = sel ? 4'b0000 : d_req;
    assign b_req = sel ? d_req : 4'b0000;
    assign a_ack = !sel && d_ack;
    assign b_ack = sel && d_ack;

    logic [3:0] m_req_ack;
    logic [7:0] m_txd;
    logic       m_txr, m_busy, m_tout;
    logic [1:0] m_gid;

    assign m_req_ack = sel ? b_req_ack : a_req_ack;
    assign m_txd     = sel ? b_txd : a_txd;
    assign m_txr     = sel ? b_txr : a_txr;
    assign m_busy    = sel ? b_busy : a_busy;
    assign m_tout    = sel ? b_tout : a_tout;
    assign m_gid     = sel ? b_gid : a_gid;

    rs232_tx_arb #(
        .NREQ        (4),
        .GAP_CYCLES  (0),
        .TIMEOUT_CYC (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (a_req),
        .req_data    (d_data),
        .req_ack     (a_req_ack),
        .ser_tx_data (a_txd),
        .ser_tx_req  (a_txr),
        .ser_tx_ack  (a_ack),
        .grant_id    (a_gid),
        .busy        (a_busy),
        .timeout_err (a_tout)
    );

    rs232_tx_arb #(
        .NREQ        (4),
        .GAP_CYCLES  (5),
        .TIMEOUT_CYC (8)
    ) u_gap (
        .clk         (clk),
        .rst         (rst),
        .req         (b_req),
        .req_data    (d_data),
        .req_ack     (b_req_ack),
        .ser_tx_data (b_txd),
        .ser_tx_req  (b_txr),
        .ser_tx_ack  (b_ack),
        .grant_id    (b_gid),
        .busy        (b_busy),
        .timeout_err (b_tout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_txr(output int n);
        n = 0;
        while (!m_txr && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && m_busy; i++) step();
    endtask

    // Called at a negedge with the selected DUT idle; ack_at = GRANT edge carrying ser_tx_ack, 0 = never.
    task automatic run_txn(input logic [3:0] r, input logic [31:0] d, input int ack_at,
                           output int lat, output logic [1:0] gid, output logic [7:0] b,
                           output int end_k, output logic [3:0] ackv, output logic tout,
                           output logic hold);
        d_req  = r;
        d_data = d;
        wait_txr(lat);
        gid   = m_gid;
        b     = m_txd;
        end_k = 0;
        ackv  = '0;
        tout  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            d_ack = (k == ack_at);
            step();
            d_ack = 1'b0;
            if (!m_txr) begin
                end_k = k;
                ackv  = m_req_ack;
                tout  = m_tout;
                break;
            end
        end
        step();
        hold = (|m_req_ack) | m_tout;
        wait_idle();
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          ack_at;
        logic [1:0]  gid;
        logic [7:0]  byte_v;
        int          end_k;
        logic [3:0]  ackv;
        logic        tout;
    } vec_t;

    localparam int NV = 13;
    localparam logic [31:0] D4 = 32'h44332211;
    vec_t vecs[NV];

    int         lat, end_k, n, low, busyc;
    logic [1:0] gid;
    logic [7:0] b;
    logic [3:0] ackv;
    logic       tout, hold;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; d_req = '0; d_data = '0; d_ack = 1'b0;

        vecs[0]  = '{4'b1111, D4,           1,  2'd0, 8'h11, 1,  4'b0001, 1'b0};
        vecs[1]  = '{4'b1111, D4,           2,  2'd1, 8'h22, 2,  4'b0010, 1'b0};
        vecs[2]  = '{4'b1111, D4,           3,  2'd2, 8'h33, 3,  4'b0100, 1'b0};
        vecs[3]  = '{4'b1111, D4,           1,  2'd3, 8'h44, 1,  4'b1000, 1'b0};
        vecs[4]  = '{4'b1111, D4,           5,  2'd0, 8'h11, 5,  4'b0001, 1'b0};
        vecs[5]  = '{4'b0100, 32'h00AA0000, 4,  2'd2, 8'hAA, 4,  4'b0100, 1'b0};
        vecs[6]  = '{4'b0010, 32'h0000BB00, 0,  2'd1, 8'hBB, 16, 4'b0000, 1'b1};
        vecs[7]  = '{4'b1111, D4,           2,  2'd2, 8'h33, 2,  4'b0100, 1'b0};
        vecs[8]  = '{4'b1000, 32'h77000000, 16, 2'd3, 8'h77, 16, 4'b1000, 1'b0};
        vecs[9]  = '{4'b1001, 32'h66000055, 15, 2'd0, 8'h55, 15, 4'b0001, 1'b0};
        vecs[10] = '{4'b0001, 32'h000000C3, 1,  2'd0, 8'hC3, 1,  4'b0001, 1'b0};
        vecs[11] = '{4'b1001, 32'h66000055, 1,  2'd3, 8'h66, 1,  4'b1000, 1'b0};
        vecs[12] = '{4'b0010, 32'h00009900, 1,  2'd1, 8'h99, 1,  4'b0010, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_txreq", m_txr, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_gid", m_gid, 0);
        chk("rst_data", m_txd, 0);
        chk("rst_ack", m_req_ack, 0);
        chk("rst_tout", m_tout, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i].req, vecs[i].data, vecs[i].ack_at, lat, gid, b, end_k, ackv, tout, hold);
            chk($sformatf("v%0d_latency", i), lat, 1);
            chk($sformatf("v%0d_grant_id", i), gid, vecs[i].gid);
            chk($sformatf("v%0d_tx_data", i), b, vecs[i].byte_v);
            chk($sformatf("v%0d_end_edge", i), end_k, vecs[i].end_k);
            chk($sformatf("v%0d_req_ack", i), ackv, vecs[i].ackv);
            chk($sformatf("v%0d_timeout_err", i), tout, vecs[i].tout);
            chk($sformatf("v%0d_pulse_width", i), hold, 0);
            chk($sformatf("v%0d_idle", i), m_busy, 0);
        end

        // Reset in the middle of a GRANT; rr_ptr is 2 beforehand.
        d_data = 32'h000000E1;
        d_req  = 4'b0001;
        wait_txr(n);
        chk("midrst_pre_gid", m_gid, 0);
        chk("midrst_pre_txreq", m_txr, 1);
        #2 rst = 1'b1;
        d_req = '0;
        #1;
        chk("midrst_txreq", m_txr, 0);
        chk("midrst_busy", m_busy, 0);
        chk("midrst_gid", m_gid, 0);
        chk("midrst_data", m_txd, 0);
        chk("midrst_ack", m_req_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(4'b0101, 32'h00F000E1, 1, lat, gid, b, end_k, ackv, tout, hold);
        chk("postrst_gid", gid, 0);
        chk("postrst_data", b, 8'hE1);
        chk("postrst_ack", ackv, 4'b0001);

        // ser_tx_ack while idle must do nothing.
        d_req = '0;
        d_ack = 1'b1;
        step();
        d_ack = 1'b0;
        chk("idle_ack_txreq", m_txr, 0);
        chk("idle_ack_reqack", m_req_ack, 0);
        chk("idle_ack_busy", m_busy, 0);

        // Requester drops req during GRANT: byte still sent and acked.
        d_data = 32'h00D20000;
        d_req  = 4'b0100;
        wait_txr(n);
        chk("drop_gid", m_gid, 2);
        d_req = '0;
        step();
        step();
        chk("drop_txreq_held", m_txr, 1);
        chk("drop_data_held", m_txd, 8'hD2);
        d_ack = 1'b1;
        step();
        d_ack = 1'b0;
        chk("drop_req_ack", m_req_ack, 4'b0100);
        wait_idle();

        // Gap instance: GAP_CYCLES=5, TIMEOUT_CYC=8.
        sel = 1'b1;
        step();
        run_txn(4'b0001, 32'h0000005C, 8, lat, gid, b, end_k, ackv, tout, hold);
        chk("g_ackto_gid", gid, 0);
        chk("g_ackto_end_edge", end_k, 8);
        chk("g_ackto_req_ack", ackv, 4'b0001);
        chk("g_ackto_timeout_err", tout, 0);
        chk("g_ackto_pulse_width", hold, 0);

        run_txn(4'b0100, 32'h00470000, 0, lat, gid, b, end_k, ackv, tout, hold);
        chk("g_to_gid", gid, 2);
        chk("g_to_end_edge", end_k, 8);
        chk("g_to_req_ack", ackv, 4'b0000);
        chk("g_to_timeout_err", tout, 1);

        d_data = 32'h6B0000A5;
        d_req  = 4'b1001;
        wait_txr(n);
        chk("g_b2b_first_gid", m_gid, 3);
        chk("g_b2b_first_data", m_txd, 8'h6B);
        d_ack = 1'b1;
        step();
        d_ack = 1'b0;
        chk("g_b2b_first_ack", m_req_ack, 4'b1000);
        d_req = 4'b0001;
        low   = 0;
        busyc = 0;
        while (!m_txr && low < 30) begin
            if (m_busy) busyc++;
            low++;
            step();
        end
        chk("g_b2b_gap_busy_cycles", busyc, 6);
        chk("g_b2b_txreq_low_cycles", low, 7);
        chk("g_b2b_second_gid", m_gid, 0);
        chk("g_b2b_second_data", m_txd, 8'hA5);
        d_ack = 1'b1;
        step();
        d_ack = 1'b0;
        chk("g_b2b_second_ack", m_req_ack, 4'b0001);
        d_req = '0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
